// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scanner for an 8-digit, 7-segment display.
// Each digit slot is CLK_DIV cycles long. The first BLANK_CYC cycles of a slot
// turn all anodes off, and the rest of the slot drives one digit.
// New data is written into a shadow copy. The shadow copy moves to the display
// copy only at a frame boundary, so a frame never shows two different values.
// Optional feature: define SEG_SCAN_LZB_EN to blank leading zeros.
module seg_scan_ctrl #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dig_en,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done,
  output logic        pending
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_BL_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {
    ST_BLANK  = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic          slot_end;

  logic [31:0]   shad_data_reg, disp_data_reg;
  logic [7:0]    shad_en_reg, disp_en_reg;
  logic          pending_reg;

  logic [7:0]    an_reg, an_next;
  logic [6:0]    seg_reg, seg_next;
  logic [7:0]    keep;
  logic [3:0]    digit_nib;

  // Standard hex glyphs. The outputs are active-low, with bit0 = a and bit6 = g.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign slot_end   = (cnt_reg == CNT_LAST);
  assign frame_done = slot_end && (idx_reg == 3'd7);
  assign pending    = pending_reg;
  assign an         = an_reg;
  assign seg        = seg_reg;

  // Slot counter and digit index. The index advances when the slot counter wraps.
  always_comb begin
    cnt_next = slot_end ? '0 : cnt_reg + CW'(1);
    idx_next = slot_end ? idx_reg + 3'd1 : idx_reg;
  end

  // Register the slot counter and the digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      idx_reg <= 3'd0;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_BLANK;
    else     state_reg <= state_next;
  end

  // FSM next state: blank for the head of each slot, then drive the digit.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_BLANK:  if (cnt_reg == CNT_BL_LAST) state_next = ST_ACTIVE;
      ST_ACTIVE: if (slot_end)               state_next = ST_BLANK;
      default:   state_next = ST_BLANK;
    endcase
  end

  // Shadow capture and frame-boundary transfer.
  // On a boundary cycle the display copy takes the old shadow value. A write
  // in that same cycle lands in the shadow copy and waits for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shad_data_reg <= 32'd0;
      shad_en_reg   <= 8'd0;
      disp_data_reg <= 32'd0;
      disp_en_reg   <= 8'd0;
      pending_reg   <= 1'b0;
    end else begin
      if (frame_done) begin
        disp_data_reg <= shad_data_reg;
        disp_en_reg   <= shad_en_reg;
      end
      if (wr_en) begin
        shad_data_reg <= wr_data;
        shad_en_reg   <= wr_dig_en;
      end
      pending_reg <= wr_en | (pending_reg & ~frame_done);
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // Leading-zero blanking. A digit stays visible if it is digit 0, or if it
  // or any higher digit holds a nonzero nibble that is enabled.
  logic [7:0] nz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_lzb
    assign nz[gi] = disp_en_reg[gi] && (disp_data_reg[4*gi +: 4] != 4'h0);
    if (gi == 0) begin : g_d0
      assign keep[gi] = 1'b1;
    end else begin : g_dn
      assign keep[gi] = |nz[7:gi];
    end
  end
`else
  assign keep = 8'hFF;
`endif

  assign digit_nib = disp_data_reg[{idx_next, 2'b00} +: 4];

  // FSM outputs, computed from the next state so that the anode and the glyph
  // update together on the same edge.
  always_comb begin
    an_next  = 8'hFF;
    seg_next = 7'h7F;
    if (state_next == ST_ACTIVE) begin
      an_next[idx_next] = 1'b0;
      if (disp_en_reg[idx_next] && keep[idx_next]) seg_next = hex_glyph(digit_nib);
    end
  end

  // Registered anode and segment outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_reg  <= 8'hFF;
      seg_reg <= 7'h7F;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000: clock cycles per digit slot, including blanking; legal range 4..2^20.
REQ-002 Parameter BLANK_CYC, default 500: cycles per slot with all anodes off (ghosting guard); legal range 1..CLK_DIV-2.
REQ-003 Port clk, input, 1: single system clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port wr_en, input, 1: one-cycle write strobe for wr_data/wr_dig_en.
REQ-006 Port wr_data, input, 32: eight hex nibbles; nibble k (bits 4k+3..4k) is shown on digit k.
REQ-007 Port wr_dig_en, input, 8: per-digit enable; bit k=0 blanks digit k.
REQ-008 Port an, output, 8: anode selects, active-low, at most one bit low at any time.
REQ-009 Port seg, output, 7: segment lines, active-low, bit0=a..bit6=g.
REQ-010 Port frame_done, output, 1: one-cycle pulse when the digit-7 slot ends.
REQ-011 Port pending, output, 1: high while a written value waits for the frame boundary.

Function
REQ-012 Shadow registers capture wr_data/wr_dig_en on the wr_en cycle; pending rises the next cycle.
REQ-013 Shadow contents transfer to display registers in the cycle frame_done is high; pending falls in the same cycle; no mid-frame tearing.
REQ-014 A wr_en in the same cycle as frame_done goes to the shadow only, is shown next frame, and leaves pending high.
REQ-015 Back-to-back writes before a boundary: last write wins.
REQ-016 Slot counter counts 0..CLK_DIV-1 and wraps; the digit index 0..7 increments at wrap; index 7 wraps to 0.
REQ-017 FSM states: BLANK (slot count < BLANK_CYC), with an=8'hFF and seg=7'h7F; ACTIVE (remaining cycles), with an[idx]=0.
REQ-018 Transitions: BLANK->ACTIVE at count==BLANK_CYC-1; ACTIVE->BLANK at count==CLK_DIV-1, which also advances the index.
REQ-019 In ACTIVE, a digit with its enable bit=0 drives an[idx]=0 and seg=7'h7F (slot timing preserved).
REQ-020 Glyphs for enabled digits are standard hex: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 an and seg are registered outputs; glyph and anode change in the same edge, with no one-cycle skew.
REQ-022 frame_done is high for exactly one cycle per 8*CLK_DIV cycles.

Reset
REQ-023 rst asserted: an=8'hFF, seg=7'h7F, frame_done=0, pending=0, counters=0, index=0, state=BLANK, display and shadow data=0, enables=0.
REQ-024 rst mid-frame aborts immediately (asynchronously); after release, scanning restarts at digit 0 BLANK, and any pending write is lost.

Configuration
REQ-025 Macro SEG_SCAN_LZB_EN defined: leading-zero blanking; digits above the highest nonzero enabled nibble are forced blank; digit 0 always shows; value 0 shows a single "0".
REQ-026 SEG_SCAN_LZB_EN undefined: zeros display as digits and only wr_dig_en blanks.

Verification (CLK_DIV=8, BLANK_CYC=2)
REQ-027 Reset release, no write -> an=FF during BLANK, then an cycles FE,FD..7F with seg=7F; frame_done every 64 cycles.
REQ-028 Write 32'h89ABCDEF, en=FF -> after the next frame_done, digit0 seg=0001110 (F) and digit7 seg=0000000 (8); pending high until the boundary.
REQ-029 Write in the frame_done cycle -> old value shown one more frame; pending stays 1; new value shown after the following frame_done.
REQ-030 Write 32'h00000012, en=FF: with LZB_EN, digits 2..7 seg=7F; without it, they show 1000000.
REQ-031 Two writes 0x11111111 then 0x22222222 mid-frame -> only 0x22222222 is ever displayed.
REQ-032 rst pulse in the digit-5 ACTIVE slot -> an=FF asynchronously; digit 0 BLANK restarts at release; a pre-reset pending write is discarded.
